// File: rtl/rect_motion_ctrl.sv
// Rectangle origin sequencer for the VGA pattern generator: detects the start of
// vertical blanking, divides frames, and bounces X/Y off the active-area edges.
module rect_motion_ctrl #(
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int W           = 20,
  parameter int H           = 100,
  parameter int X_INIT      = 50,
  parameter int Y_INIT      = 50,
  parameter int DIV_BITS    = 4
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic [9:0]          i_Col_Count,
  input  logic [9:0]          i_Row_Count,
  input  logic                i_Run,
  input  logic                i_Step,
  input  logic [2:0]          i_Speed,
  input  logic [DIV_BITS-1:0] i_Div,
  input  logic                i_Load,
  input  logic [9:0]          i_Load_X,
  input  logic [9:0]          i_Load_Y,
  output logic [9:0]          o_X,
  output logic [9:0]          o_Y,
  output logic                o_Dir_X,
  output logic                o_Dir_Y,
  output logic                o_Frame_Tick,
  output logic                o_Moved
);

  localparam logic [9:0] X_MAX = 10'(ACTIVE_COLS - W);
  localparam logic [9:0] Y_MAX = 10'(ACTIVE_ROWS - H);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MOVE_X, S_MOVE_Y} state_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
  } axis_t;

  state_t              state;
  logic [DIV_BITS-1:0] div_cnt;
  logic                step_armed;
  logic                frame_match;
  axis_t               next_x;
  axis_t               next_y;

  // The 11-bit sum keeps pos+speed from wrapping before the bound compare.
  function automatic axis_t bounce(input logic [9:0] pos, input logic dir,
                                   input logic [2:0] spd, input logic [9:0] lim);
    axis_t       r;
    logic [10:0] sum;
    r.pos = pos;
    r.dir = dir;
    sum   = {1'b0, pos} + {8'b0, spd};
    if (dir) begin
      if (sum > {1'b0, lim}) begin
        r.pos = lim;
        r.dir = 1'b0;
      end else begin
        r.pos = sum[9:0];
      end
    end else if ({7'b0, spd} > pos) begin
      r.pos = '0;
      r.dir = 1'b1;
    end else begin
      r.pos = pos - {7'b0, spd};
    end
    return r;
  endfunction

  assign frame_match = (i_Col_Count == 10'(ACTIVE_COLS)) && (i_Row_Count == 10'(ACTIVE_ROWS));
  assign next_x      = bounce(o_X, o_Dir_X, i_Speed, X_MAX);
  assign next_y      = bounce(o_Y, o_Dir_Y, i_Speed, Y_MAX);

  // NOTE: every register here uses <= so all state updates see pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      step_armed   <= 1'b0;
      o_X          <= 10'(X_INIT);
      o_Y          <= 10'(Y_INIT);
      o_Dir_X      <= 1'b1;
      o_Dir_Y      <= 1'b1;
      o_Frame_Tick <= 1'b0;
      o_Moved      <= 1'b0;
    end else begin
      o_Frame_Tick <= frame_match;
      o_Moved      <= 1'b0;
      if (i_Load) begin
        o_X        <= (i_Load_X > X_MAX) ? X_MAX : i_Load_X;
        o_Y        <= (i_Load_Y > Y_MAX) ? Y_MAX : i_Load_Y;
        o_Dir_X    <= 1'b1;
        o_Dir_Y    <= 1'b1;
        div_cnt    <= '0;
        step_armed <= 1'b0;
        state      <= i_Run ? S_WAIT : S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_Run) begin
              state      <= S_WAIT;
              div_cnt    <= '0;
              step_armed <= 1'b0;
            end else if (o_Frame_Tick && step_armed) begin
              state      <= S_MOVE_X;
              step_armed <= 1'b0;
            end else if (i_Step) begin
              step_armed <= 1'b1;
            end
          end
          S_WAIT: begin
            if (!i_Run) begin
              state <= S_IDLE;
            end else if (o_Frame_Tick) begin
              if (div_cnt == i_Div) begin
                div_cnt <= '0;
                state   <= S_MOVE_X;
              end else begin
                div_cnt <= div_cnt + DIV_BITS'(1);
              end
            end
          end
          S_MOVE_X: begin
            o_X     <= next_x.pos;
            o_Dir_X <= next_x.dir;
            state   <= S_MOVE_Y;
          end
          S_MOVE_Y: begin
            o_Y     <= next_y.pos;
            o_Dir_Y <= next_y.dir;
            o_Moved <= 1'b1;
            state   <= i_Run ? S_WAIT : S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rect_motion_ctrl.sv
// Bench for rect_motion_ctrl: a compressed 40-cycle raster drives the counters,
// a behavioural model predicts every output, and directed frames pin literal values.
module tb_rect_motion_ctrl;

  localparam int FL   = 40;
  localparam int XMAX = 620;
  localparam int YMAX = 380;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] col = '0, row = '0;
  logic       run = 1'b0, step = 1'b0, load = 1'b0;
  logic [2:0] speed = '0;
  logic [3:0] div = '0;
  logic [9:0] load_x = '0, load_y = '0;
  logic [9:0] x, y;
  logic       dir_x, dir_y, frame_tick, moved;

  rect_motion_ctrl dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Col_Count(col), .i_Row_Count(row),
    .i_Run(run), .i_Step(step), .i_Speed(speed), .i_Div(div),
    .i_Load(load), .i_Load_X(load_x), .i_Load_Y(load_y),
    .o_X(x), .o_Y(y), .o_Dir_X(dir_x), .o_Dir_Y(dir_y),
    .o_Frame_Tick(frame_tick), .o_Moved(moved)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int moves_seen = 0, ticks_seen = 0;
  bit cmp_en = 1'b0;
  int x_at[FL], y_at[FL];

  // Model: position/direction per axis, a "move phase" (0 none, 1 X next, 2 Y next),
  // whether motion is free-running, the frame divider and the armed single step.
  int m_x, m_y, m_dx, m_dy, m_tick, m_moved, m_phase, m_cnt;
  bit m_running, m_armed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_x = 50; m_y = 50; m_dx = 1; m_dy = 1; m_tick = 0; m_moved = 0;
    m_phase = 0; m_cnt = 0; m_running = 1'b0; m_armed = 1'b0;
  endfunction

  function automatic void bounce(inout int p, inout int d, input int s, input int lim);
    if (d == 1) begin
      if (p + s > lim) begin p = lim; d = 0; end
      else p = p + s;
    end else begin
      if (s > p) begin p = 0; d = 1; end
      else p = p - s;
    end
  endfunction

  // One clock: set raster position, predict the next outputs, clock, commit.
  task automatic cycle(input int p);
    int nx, ny, ndx, ndy, nphase, ncnt, ntick, nmoved;
    bit nrun, narm;
    col = 10'(635 + p % 10);
    row = 10'(478 + p / 10);
    nx = m_x; ny = m_y; ndx = m_dx; ndy = m_dy; nphase = m_phase; ncnt = m_cnt;
    nrun = m_running; narm = m_armed; nmoved = 0;
    ntick = (col == 10'd640 && row == 10'd480) ? 1 : 0;
    if (load) begin
      nx = (int'(load_x) > XMAX) ? XMAX : int'(load_x);
      ny = (int'(load_y) > YMAX) ? YMAX : int'(load_y);
      ndx = 1; ndy = 1; ncnt = 0; narm = 1'b0; nphase = 0; nrun = run;
    end else if (m_phase == 1) begin
      bounce(nx, ndx, int'(speed), XMAX);
      nphase = 2;
    end else if (m_phase == 2) begin
      bounce(ny, ndy, int'(speed), YMAX);
      nmoved = 1; nphase = 0; nrun = run;
    end else if (!m_running) begin
      if (run) begin nrun = 1'b1; ncnt = 0; narm = 1'b0; end
      else if (m_tick == 1 && m_armed) begin nphase = 1; narm = 1'b0; end
      else if (step) narm = 1'b1;
    end else begin
      if (!run) nrun = 1'b0;
      else if (m_tick == 1) begin
        if (m_cnt == int'(div)) begin ncnt = 0; nphase = 1; end
        else ncnt = m_cnt + 1;
      end
    end
    @(posedge clk);
    #1;
    m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy; m_phase = nphase; m_cnt = ncnt;
    m_running = nrun; m_armed = narm; m_tick = ntick; m_moved = nmoved;
    x_at[p] = int'(x);
    y_at[p] = int'(y);
    @(negedge clk);
    load = 1'b0;
    step = 1'b0;
  endtask

  task automatic run_frame();
    for (int p = 0; p < FL; p++) cycle(p);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("o_X", 32'(x), 32'(m_x));
      check("o_Y", 32'(y), 32'(m_y));
      check("o_Dir_X", 32'(dir_x), 32'(m_dx));
      check("o_Dir_Y", 32'(dir_y), 32'(m_dy));
      check("o_Frame_Tick", 32'(frame_tick), 32'(m_tick));
      check("o_Moved", 32'(moved), 32'(m_moved));
      if (moved) moves_seen++;
      if (frame_tick) ticks_seen++;
    end
  end

  initial begin
    model_reset();
    #12;
    check("reset_x", 32'(x), 32'd50);
    check("reset_y", 32'(y), 32'd50);
    check("reset_dirs", {30'd0, dir_x, dir_y}, 32'd3);
    check("reset_pulses", {30'd0, frame_tick, moved}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 cmp_en = 1'b1;

    // Paused: ticks but no motion.
    run_frame(); run_frame();
    check("paused_ticks", 32'(ticks_seen), 32'd2);
    check("paused_moves", 32'(moves_seen), 32'd0);
    check("paused_x", 32'(x), 32'd50);

    // Running, speed 3, every frame; X lands 2 and Y 3 cycles after the match.
    run = 1'b1; speed = 3'd3; div = 4'd0;
    run_frame();
    check("lat_x_before", 32'(x_at[26]), 32'd50);
    check("lat_x_after", 32'(x_at[27]), 32'd53);
    check("lat_y_before", 32'(y_at[27]), 32'd50);
    check("lat_y_after", 32'(y_at[28]), 32'd53);
    run_frame(); run_frame();
    check("three_frames_x", 32'(x), 32'd59);
    check("three_frames_y", 32'(y), 32'd59);

    // Bounce at the right edge, then at the bottom edge.
    speed = 3'd4; load = 1'b1; load_x = 10'd617; load_y = 10'd375;
    run_frame();
    check("edge_x", 32'(x), 32'd620);
    check("edge_dir_x", 32'(dir_x), 32'd0);
    check("edge_y", 32'(y), 32'd379);
    run_frame();
    check("edge2_x", 32'(x), 32'd616);
    check("edge2_y", 32'(y), 32'd380);
    check("edge2_dir_y", 32'(dir_y), 32'd0);

    // Load clamps; a load during the tick cycle suppresses that frame's move.
    load = 1'b1; load_x = 10'd700; load_y = 10'd900;
    cycle(0);
    check("clamp_x", 32'(x), 32'd620);
    check("clamp_y", 32'(y), 32'd380);
    for (int p = 1; p < 26; p++) cycle(p);
    check("tick_visible", 32'(frame_tick), 32'd1);
    moves_seen = 0;
    load = 1'b1;
    for (int p = 26; p < FL; p++) cycle(p);
    check("load_on_tick_moves", 32'(moves_seen), 32'd0);
    check("load_on_tick_x", 32'(x), 32'd620);

    // Single step while paused.
    run = 1'b0; speed = 3'd2; load = 1'b1; load_x = 10'd100; load_y = 10'd100;
    moves_seen = 0;
    for (int p = 0; p < FL; p++) begin
      if (p == 10) step = 1'b1;
      cycle(p);
    end
    check("step_x", 32'(x), 32'd102);
    check("step_y", 32'(y), 32'd102);
    check("step_moves", 32'(moves_seen), 32'd1);
    run_frame();
    check("no_step_moves", 32'(moves_seen), 32'd1);

    // Divider 3: one move per four ticks.
    run = 1'b1; div = 4'd3; speed = 3'd1; moves_seen = 0;
    load = 1'b1; load_x = 10'd100; load_y = 10'd100;
    for (int f = 0; f < 8; f++) run_frame();
    check("div_moves", 32'(moves_seen), 32'd2);
    check("div_x", 32'(x), 32'd102);

    // Asynchronous reset while the Y update is pending.
    div = 4'd0;
    for (int p = 0; p < 28; p++) cycle(p);
    check("mid_move_x_updated", 32'(x), 32'd103);
    cmp_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_x", 32'(x), 32'd50);
    check("async_rst_y", 32'(y), 32'd50);
    check("async_rst_moved", 32'(moved), 32'd0);
    model_reset();
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 cmp_en = 1'b1;
    run_frame();
    check("post_rst_idle_x", 32'(x), 32'd50);

    // Randomised frames checked cycle by cycle against the model.
    for (int f = 0; f < 150; f++) begin
      run   = ($urandom_range(0, 9) < 7);
      speed = 3'($urandom_range(0, 7));
      div   = 4'($urandom_range(0, 3));
      for (int p = 0; p < FL; p++) begin
        step = ($urandom_range(0, 29) == 0);
        if ($urandom_range(0, 299) == 0) begin
          load   = 1'b1;
          load_x = 10'($urandom_range(0, 1023));
          load_y = 10'($urandom_range(0, 1023));
        end
        if ($urandom_range(0, 49) == 0) speed = 3'($urandom_range(0, 7));
        cycle(p);
      end
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rect_motion_ctrl.md
Name: rect_motion_ctrl

Overview:
- Sequences the position of the on-screen rectangle drawn by the VGA pattern logic.
- Watches the VGA column/row counts for the start of vertical blanking and advances X/Y once every N frames.
- Bounces off the active-area edges, and supports run/pause, single-step and direct position load.
- Outputs feed the pattern comparator's rectangle origin. Positions only change during blanking, so there is no tearing.

Parameters:
- ACTIVE_COLS, 640: active columns; X range is 0..ACTIVE_COLS-W.
- ACTIVE_ROWS, 480: active rows; Y range is 0..ACTIVE_ROWS-H.
- W, 20: rectangle width in pixels.
- H, 100: rectangle height in pixels.
- X_INIT, 50: reset X position.
- Y_INIT, 50: reset Y position.
- DIV_BITS, 4: width of the frame-divider input.

Ports:
- i_Clk  in  1  pixel clock, shared with the VGA counter.
- i_Rst_L  in  1  reset, asynchronous, active-low.
- i_Col_Count  in  10  current column from the VGA counter.
- i_Row_Count  in  10  current row from the VGA counter.
- i_Run  in  1  level; 1 = move continuously, 0 = paused.
- i_Step  in  1  one-cycle pulse; while paused, arms a single move at the next update point.
- i_Speed  in  3  pixels per move on each axis; 0 = no motion.
- i_Div  in  DIV_BITS  move every i_Div+1 frames.
- i_Load  in  1  one-cycle pulse; load i_Load_X/i_Load_Y.
- i_Load_X  in  10  X value to load.
- i_Load_Y  in  10  Y value to load.
- o_X  out  10  rectangle origin X (registered).
- o_Y  out  10  rectangle origin Y (registered).
- o_Dir_X  out  1  1 = moving +X (right).
- o_Dir_Y  out  1  1 = moving +Y (down).
- o_Frame_Tick  out  1  one-cycle pulse at each detected frame boundary.
- o_Moved  out  1  one-cycle pulse on the cycle the Y update is written.

Behaviour:
- Clock and reset: single clock i_Clk. Reset is asynchronous, active-low (i_Rst_L).
- Reset values:
  - o_X=X_INIT, o_Y=Y_INIT.
  - o_Dir_X=1, o_Dir_Y=1.
  - o_Frame_Tick=0, o_Moved=0.
  - State = S_IDLE, divider count=0, step_armed=0.
  - Reset mid-move abandons the move immediately; no partial update survives.
- Frame tick:
  - Fires when i_Col_Count==ACTIVE_COLS and i_Row_Count==ACTIVE_ROWS (first blanking pixel of the first blanking line).
  - o_Frame_Tick is registered and asserted the cycle after that match. Exactly one per frame.
- Divider:
  - Counts frame ticks while in S_WAIT.
  - An update is due when count==i_Div; the count then returns to 0.
  - i_Div=0 means every frame.
- States:
  - S_IDLE:
    - Paused; o_Frame_Tick still pulses.
    - An i_Step pulse sets step_armed.
    - On a frame tick with step_armed=1: go to S_MOVE_X and clear step_armed. The divider is ignored.
    - i_Run=1 -> S_WAIT, with the divider count cleared.
  - S_WAIT:
    - On a frame tick with the update due -> S_MOVE_X.
    - i_Run=0 -> S_IDLE at the next cycle. A pending move that has not started is dropped.
  - S_MOVE_X (1 cycle):
    - Compute the next X in 11-bit unsigned arithmetic.
    - If Dir_X=1 and o_X+i_Speed > ACTIVE_COLS-W: o_X = ACTIVE_COLS-W and Dir_X flips to 0.
    - If Dir_X=0 and i_Speed > o_X: o_X = 0 and Dir_X flips to 1.
    - Otherwise o_X = o_X ± i_Speed.
    - Next state is S_MOVE_Y.
  - S_MOVE_Y (1 cycle):
    - Same rules as S_MOVE_X, using ACTIVE_ROWS-H and Dir_Y.
    - Pulse o_Moved.
    - Return to S_WAIT if i_Run=1, else S_IDLE.
- Landing exactly on a bound (e.g. o_X+i_Speed == ACTIVE_COLS-W) does not flip direction. The flip happens on the next move.
- i_Speed=0: the states are still traversed and o_Moved still pulses; position and directions are unchanged.
- Latency: from the frame-boundary match to the new o_X is 2 cycles, and to the new o_Y is 3 cycles. Both land well inside blanking.
- i_Load:
  - Highest priority, in any state.
  - o_X = min(i_Load_X, ACTIVE_COLS-W) and o_Y = min(i_Load_Y, ACTIVE_ROWS-H).
  - Directions reset to 1,1; divider count and step_armed are cleared.
  - State goes to S_WAIT if i_Run=1, else S_IDLE. Any in-flight move is cancelled.
- Load on the same cycle as a frame tick: the load wins and no move starts on that tick.
- Step while running: ignored (not armed).
- Inputs i_Speed and i_Div are sampled at the cycle of use; changing them mid-move affects only subsequent computations.

Test Plan:
- Reset then release, i_Run=0, two frames: o_X=50, o_Y=50, o_Moved never asserts, o_Frame_Tick pulses once per frame (every 800*525 clocks).
- i_Run=1, i_Speed=3, i_Div=0: after 1 frame o_X=53, o_Y=53; after 3 frames o_X=59, o_Y=59. o_X changes 2 cycles and o_Y 3 cycles after Col=640/Row=480.
- Load X=617, Y=375, speed=4, run: next frame o_X=620, Dir_X=0, o_Y=379; following frame o_X=616, o_Y=380, Dir_Y=0.
- Load X=700, Y=900: o_X=620, o_Y=380 immediately after the load. A load on the same cycle as a frame tick produces no move that frame.
- Paused, i_Step pulse mid-frame, i_Speed=2: exactly one move at the next boundary (+2,+2). A second frame with no step produces no move.
- i_Div=3, running: moves only on every 4th frame tick. Asserting i_Rst_L=0 during S_MOVE_Y restores X_INIT/Y_INIT and S_IDLE asynchronously.
